// File: rtl/hex_display_scanner_pkg.sv
// Shared 7-segment definitions: active-low hex glyphs {g,f,e,d,c,b,a} and the all-off pattern.
package hex_display_scanner_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] HEX7_0 = 7'h40;
  localparam logic [6:0] HEX7_1 = 7'h79;
  localparam logic [6:0] HEX7_2 = 7'h24;
  localparam logic [6:0] HEX7_3 = 7'h30;
  localparam logic [6:0] HEX7_4 = 7'h19;
  localparam logic [6:0] HEX7_5 = 7'h12;
  localparam logic [6:0] HEX7_6 = 7'h02;
  localparam logic [6:0] HEX7_7 = 7'h78;
  localparam logic [6:0] HEX7_8 = 7'h00;
  localparam logic [6:0] HEX7_9 = 7'h10;
  localparam logic [6:0] HEX7_A = 7'h08;
  localparam logic [6:0] HEX7_B = 7'h03;
  localparam logic [6:0] HEX7_C = 7'h46;
  localparam logic [6:0] HEX7_D = 7'h21;
  localparam logic [6:0] HEX7_E = 7'h06;
  localparam logic [6:0] HEX7_F = 7'h0E;

endpackage

// File: rtl/hex_display_scanner_hex_to_seg.sv
// Combinational nibble to active-low 7-segment decoder.
module hex_to_seg
  import hex_display_scanner_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = SEG_OFF;
    case (nibble_i)
      4'h0: seg_n_o = HEX7_0;
      4'h1: seg_n_o = HEX7_1;
      4'h2: seg_n_o = HEX7_2;
      4'h3: seg_n_o = HEX7_3;
      4'h4: seg_n_o = HEX7_4;
      4'h5: seg_n_o = HEX7_5;
      4'h6: seg_n_o = HEX7_6;
      4'h7: seg_n_o = HEX7_7;
      4'h8: seg_n_o = HEX7_8;
      4'h9: seg_n_o = HEX7_9;
      4'hA: seg_n_o = HEX7_A;
      4'hB: seg_n_o = HEX7_B;
      4'hC: seg_n_o = HEX7_C;
      4'hD: seg_n_o = HEX7_D;
      4'hE: seg_n_o = HEX7_E;
      4'hF: seg_n_o = HEX7_F;
      default: seg_n_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/hex_display_scanner.sv
// Multiplexed 7-segment scanner: per-frame snapshot of all nibbles, guard-blanked slots,
// optional leading-zero suppression, registered outputs.
module hex_display_scanner
  import hex_display_scanner_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_PERIOD = 1000,
  parameter int GUARD        = 2,
  parameter int BLANK_LZ     = 1,
  localparam int PW = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [IW-1:0]           digit_sel,
  output logic                    frame_start
);

  localparam logic [PW-1:0] P_LAST  = PW'(DIGIT_PERIOD - 1);
  localparam logic [PW-1:0] P_GUARD = PW'(GUARD);
  localparam logic [IW-1:0] I_LAST  = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           p_q, p_d;
  logic [IW-1:0]           i_q, i_d;
  logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
  logic [NUM_DIGITS-1:0]   sdp_q, sdp_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    load;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    all_zero;
  logic                    show;
  logic [3:0]              nibble;
  logic [6:0]              seg_dec;

  hex_to_seg u_hex_to_seg (
    .nibble_i (nibble),
    .seg_n_o  (seg_dec)
  );

  always_comb begin
    load   = (p_q == '0) && (i_q == '0);
    p_d    = p_q + PW'(1);
    i_d    = i_q;
    if (p_q == P_LAST) begin
      p_d = '0;
      i_d = (i_q == I_LAST) ? '0 : i_q + IW'(1);
    end
    snap_d = load ? digits_in : snap_q;
    sdp_d  = load ? dp_in : sdp_q;
  end

  // Digit k>0 is a leading zero when it and every more-significant nibble are zero.
  always_comb begin
    blank_mask = '0;
    all_zero   = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      all_zero      = all_zero && (snap_d[4*k +: 4] == 4'h0);
      blank_mask[k] = all_zero;
    end
  end

  always_comb begin
    nibble = snap_d[4*int'(i_q) +: 4];
    show   = (p_q >= P_GUARD) && !((BLANK_LZ != 0) && blank_mask[i_q]);
    seg_d  = SEG_OFF;
    dp_d   = 1'b1;
    an_d   = '1;
    if (show) begin
      seg_d = seg_dec;
      dp_d  = ~sdp_d[i_q];
      an_d  = ~(NUM_DIGITS'(1) << i_q);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p_q         <= '0;
      i_q         <= '0;
      snap_q      <= '0;
      sdp_q       <= '0;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
      an_q        <= '1;
      digit_sel   <= '0;
      frame_start <= 1'b0;
    end else if (enable) begin
      p_q         <= p_d;
      i_q         <= i_d;
      snap_q      <= snap_d;
      sdp_q       <= sdp_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
      digit_sel   <= i_q;
      frame_start <= load;
    end else begin
      frame_start <= 1'b0;
    end
  end

  assign seg_n = seg_q;
  assign dp_n  = dp_q;
  assign an_n  = an_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Randomized bench for hex_display_scanner against a frame/slot arithmetic reference model.
module tb_hex_display_scanner;

  localparam int ND = 4;
  localparam int DP = 8;
  localparam int GD = 2;
  localparam int FRAME = ND * DP;
  localparam logic [14:0] BLANK_RST = {7'h7F, 1'b1, 4'hF, 2'd0, 1'b0};

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;

  logic [6:0] seg_n0, seg_n1;
  logic       dp_n0, dp_n1;
  logic [3:0] an_n0, an_n1;
  logic [1:0] sel0, sel1;
  logic       fs0, fs1;
  logic [14:0] obs0, obs1;

  assign obs0 = {seg_n0, dp_n0, an_n0, sel0, fs0};
  assign obs1 = {seg_n1, dp_n1, an_n1, sel1, fs1};

  always #5 clock = ~clock;

  hex_display_scanner #(.NUM_DIGITS(ND), .DIGIT_PERIOD(DP), .GUARD(GD), .BLANK_LZ(0)) u_dut_nb (
    .clock(clock), .reset(reset), .enable(enable), .digits_in(digits_in), .dp_in(dp_in),
    .seg_n(seg_n0), .dp_n(dp_n0), .an_n(an_n0), .digit_sel(sel0), .frame_start(fs0));

  hex_display_scanner #(.NUM_DIGITS(ND), .DIGIT_PERIOD(DP), .GUARD(GD), .BLANK_LZ(1)) u_dut_lz (
    .clock(clock), .reset(reset), .enable(enable), .digits_in(digits_in), .dp_in(dp_in),
    .seg_n(seg_n1), .dp_n(dp_n1), .an_n(an_n1), .digit_sel(sel1), .frame_start(fs1));

  logic [6:0] HEX7 [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int          checks = 0;
  int          passes = 0;
  int          m_n;
  logic [15:0] m_snap;
  logic [3:0]  m_dp;
  logic [14:0] exp0, exp1;

  function automatic logic [14:0] render(int p, int i, bit blz, bit ld);
    logic [6:0]  s = 7'h7F;
    logic        d = 1'b1;
    logic [3:0]  a = 4'hF;
    logic [15:0] upper;
    upper = m_snap >> (4 * i);
    if (p >= GD && !(blz && i > 0 && upper == 16'h0)) begin
      s = HEX7[upper[3:0]];
      d = ~m_dp[i];
      a = ~(4'b0001 << i);
    end
    return {s, d, a, 2'(i), ld};
  endfunction

  // Slot and digit derive from the count of enabled edges since reset.
  task automatic model_edge();
    int p, i;
    bit ld;
    if (!reset) begin
      m_n = 0; m_snap = '0; m_dp = '0;
      exp0 = BLANK_RST; exp1 = BLANK_RST;
      return;
    end
    if (!enable) begin
      exp0[0] = 1'b0; exp1[0] = 1'b0;
      return;
    end
    p  = m_n % DP;
    i  = (m_n / DP) % ND;
    ld = (m_n % FRAME) == 0;
    if (ld) begin m_snap = digits_in; m_dp = dp_in; end
    exp0 = render(p, i, 1'b0, ld);
    exp1 = render(p, i, 1'b1, ld);
    m_n++;
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; digits_in = 16'h1234; dp_in = 4'h0;
    #2;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++; if (obs0 !== BLANK_RST) $display("FAIL reset_nb k=%0d got=%h exp=%h", k, obs0, BLANK_RST); else passes++;
      checks++; if (obs1 !== BLANK_RST) $display("FAIL reset_lz k=%0d got=%h exp=%h", k, obs1, BLANK_RST); else passes++;
    end
  endtask

  task automatic test_scan();
    reset = 1'b1; digits_in = 16'h1234; dp_in = 4'b0100;
    while (m_n < 40) begin
      tick();
      checks++; if (obs0 !== exp0) $display("FAIL scan_nb n=%0d got=%h exp=%h", m_n, obs0, exp0); else passes++;
      checks++; if (obs1 !== exp1) $display("FAIL scan_lz n=%0d got=%h exp=%h", m_n, obs1, exp1); else passes++;
      if (m_n == 3) begin
        checks++; if ({an_n0, seg_n0} !== {4'b1110, 7'h19}) $display("FAIL slot0_lit got=%b/%h exp=1110/19", an_n0, seg_n0); else passes++;
      end
      if (m_n == 28) begin
        checks++; if ({an_n0, seg_n0} !== {4'b0111, 7'h79}) $display("FAIL slot3_lit got=%b/%h exp=0111/79", an_n0, seg_n0); else passes++;
      end
      if (m_n == 33) begin
        checks++; if (fs0 !== 1'b1) $display("FAIL frame_period got=%b exp=1", fs0); else passes++;
      end
    end
  endtask

  task automatic test_no_tearing();
    digits_in = 16'hABCD;
    while (m_n < 96) begin
      tick();
      checks++; if (obs0 !== exp0) $display("FAIL tear_nb n=%0d got=%h exp=%h", m_n, obs0, exp0); else passes++;
      checks++; if (obs1 !== exp1) $display("FAIL tear_lz n=%0d got=%h exp=%h", m_n, obs1, exp1); else passes++;
      if (m_n == 60) begin
        checks++; if (seg_n0 !== 7'h79) $display("FAIL tear_old got=%h exp=79", seg_n0); else passes++;
      end
      if (m_n == 67) begin
        checks++; if (seg_n0 !== 7'h21) $display("FAIL tear_new_d0 got=%h exp=21", seg_n0); else passes++;
      end
      if (m_n == 91) begin
        checks++; if (seg_n0 !== 7'h08) $display("FAIL tear_new_d3 got=%h exp=08", seg_n0); else passes++;
      end
    end
  endtask

  task automatic test_blanking();
    logic [15:0] pats [3] = '{16'h0040, 16'h0000, 16'h0F00};
    int lit_hi;
    dp_in = 4'h0;
    for (int t = 0; t < 3; t++) begin
      while ((m_n % FRAME) != 0) tick();
      digits_in = pats[t];
      lit_hi = 0;
      for (int k = 0; k < FRAME; k++) begin
        tick();
        checks++; if (obs0 !== exp0) $display("FAIL blank_nb n=%0d got=%h exp=%h", m_n, obs0, exp0); else passes++;
        checks++; if (obs1 !== exp1) $display("FAIL blank_lz n=%0d got=%h exp=%h", m_n, obs1, exp1); else passes++;
        if (t == 1 && an_n1[3:1] != 3'b111) lit_hi++;
      end
      if (t == 1) begin
        checks++; if (lit_hi != 0) $display("FAIL zero_only_d0 got=%0d lit cycles exp=0", lit_hi); else passes++;
      end
    end
  endtask

  task automatic test_freeze();
    logic [14:0] held;
    digits_in = 16'h5678;
    while ((m_n % FRAME) != 2 * DP + 5) tick();
    enable = 1'b0;
    held = obs0;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++; if (obs0 !== exp0) $display("FAIL freeze_nb k=%0d got=%h exp=%h", k, obs0, exp0); else passes++;
      checks++; if ({an_n0, fs0} !== {4'b1011, 1'b0}) $display("FAIL freeze_an k=%0d got=%b/%b exp=1011/0", k, an_n0, fs0); else passes++;
    end
    enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++; if (obs0 !== exp0) $display("FAIL resume_nb k=%0d got=%h exp=%h", k, obs0, exp0); else passes++;
      checks++; if (obs1 !== exp1) $display("FAIL resume_lz k=%0d got=%h exp=%h", k, obs1, exp1); else passes++;
    end
  endtask

  task automatic test_reset_midframe();
    while ((m_n % FRAME) != DP + 4) tick();
    #2;
    reset = 1'b0;
    #1;
    checks++; if (obs0 !== BLANK_RST) $display("FAIL async_reset got=%h exp=%h", obs0, BLANK_RST); else passes++;
    tick();
    reset = 1'b1;
    for (int k = 0; k < 36; k++) begin
      tick();
      checks++; if (obs0 !== exp0) $display("FAIL restart_nb n=%0d got=%h exp=%h", m_n, obs0, exp0); else passes++;
      checks++; if (obs1 !== exp1) $display("FAIL restart_lz n=%0d got=%h exp=%h", m_n, obs1, exp1); else passes++;
      if (k == 0) begin
        checks++; if ({fs0, sel0} !== {1'b1, 2'd0}) $display("FAIL restart_fs got=%b/%0d exp=1/0", fs0, sel0); else passes++;
      end
    end
  endtask

  task automatic test_live_counter();
    logic [3:0] cnt = 4'hC;
    bit legal;
    for (int k = 0; k < 600; k++) begin
      cnt = cnt + 4'h1;
      digits_in = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 2)), cnt};
      dp_in     = 4'($urandom);
      enable    = ($urandom_range(0, 7) != 0);
      tick();
      checks++; if (obs0 !== exp0) $display("FAIL live_nb n=%0d got=%h exp=%h", m_n, obs0, exp0); else passes++;
      checks++; if (obs1 !== exp1) $display("FAIL live_lz n=%0d got=%h exp=%h", m_n, obs1, exp1); else passes++;
      legal = (seg_n1 == 7'h7F);
      for (int h = 0; h < 16; h++) if (seg_n1 == HEX7[h]) legal = 1'b1;
      checks++; if (!legal || $countones(~an_n1) > 1) $display("FAIL live_legal got seg=%h an=%b exp legal glyph, <=1 anode", seg_n1, an_n1); else passes++;
    end
    enable = 1'b1;
  endtask

  initial begin
    m_n = 0; m_snap = '0; m_dp = '0; exp0 = BLANK_RST; exp1 = BLANK_RST;
    test_reset();
    test_scan();
    test_no_tearing();
    test_blanking();
    test_freeze();
    test_reset_midframe();
    test_live_counter();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
